serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//  Serial-to-parallel receiver: the consumer end of the serial bit stream that the sequence
//  generator / shift-register stage produces. It hunts for a sync word and, once locked,
//  deserialises WIDTH-bit words MSB-first. It re-checks sync after every FRAME_WORDS words
//  and reports loss of lock. It sits between a 1-bit serial source and parallel logic.
// PARAMETERS
//  WIDTH         4        data word width in bits
//  SYNC_LEN      4        sync word length in bits
//  SYNC_PATTERN  4'b1101  sync word, MSB received first
//  FRAME_WORDS   2        data words between consecutive sync words (>=1)
//  CNT_W         8        width of frame_cnt
// PORTS
//  clk         in   1         single system clock, all state updates on posedge
//  rst         in   1         asynchronous, active-high reset
//  bit_in      in   1         serial data bit
//  bit_valid   in   1         bit_in is sampled only on clk edges where bit_valid=1
//  word_out    out  WIDTH     last completed data word, held until the next word completes
//  word_valid  out  1         one-cycle pulse: word_out has just been updated
//  sync_lock   out  1         1 while in DATA or CHECK state
//  sync_err    out  1         one-cycle pulse: sync re-check failed
//  frame_cnt   out  CNT_W     count of successful sync re-checks, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: async; state=HUNT. word_out=0, word_valid=0, sync_lock=0, sync_err=0, frame_cnt=0.
//    Sync window, fill, bit, word and check counters are all cleared.
//  - Reset asserted mid-word or mid-check discards all partial data. No output holds a stale value.
//  - bit_valid=0: no state or counter changes. word_valid and sync_err still drop after 1 cycle.
//  - HUNT: each valid bit shifts into a SYNC_LEN window, new bit at the LSB. A fill counter
//    saturates at SYNC_LEN. A match needs fill==SYNC_LEN (including the current bit) and
//    window==SYNC_PATTERN. On a match, at the same edge: state->DATA, sync_lock<=1, and
//    bit/word counters<=0. Overlapping patterns are allowed; the window keeps sliding each bit.
//  - DATA: each valid bit shifts into the data register, MSB-first. The first bit of a word
//    ends up in word_out[WIDTH-1]. On the WIDTH-th bit, at the same edge:
//    word_out<={reg,bit_in}, word_valid<=1 for exactly one cycle, bit_cnt<=0, word_cnt++.
//    If this was word FRAME_WORDS, then state->CHECK, chk_cnt<=0 and word_cnt<=0.
//  - Latency: word_out is valid on the edge that samples the word's last bit (0 extra cycles).
//  - CHECK: SYNC_LEN valid bits are compared against SYNC_PATTERN, MSB first. Any mismatch
//    sets a sticky error flag. The decision is made only on the SYNC_LEN-th bit, never early.
//    * all bits matched: state->DATA, frame_cnt++ (wraps), sync_lock stays 1.
//    * any mismatch: state->HUNT, sync_lock<=0, sync_err<=1 for one cycle, fill counter<=0.
//      The failed check bits are not reused for hunting.
//  - sync_lock is registered; it changes on the same edge as the state transition.
//  - word_valid and sync_err are never both 1. Neither is ever high for two consecutive cycles.
//  - Illegal or unused state encoding: go to HUNT with sync_lock=0.
// STRUCTURE
//  - Shared package rx_pkg holds: state localparams ST_HUNT=2'd0, ST_DATA=2'd1,
//    ST_CHECK=2'd2, and the default SYNC_PATTERN/SYNC_LEN constants.
//  - Sub-module serial_shift_in #(N): N-bit shift-in register with enable and clear, MSB-first.
//    Instantiate it once for the sync window and once for the data register.
//  - Top level: FSM, counters (bit, word, check, fill, frame) and registered outputs.
// TESTING
//  1. rst=1, then release. Send 1,1,0,1 with bit_valid=1 -> sync_lock=1 at the 4th-bit edge,
//     word_valid=0. Also: after reset, sending only 1,0,1 -> no lock (fill counter guard).
//  2. Locked, send 0,1,1,0 then 1,0,1,0 -> word_out=4'h6 with a 1-cycle word_valid, then
//     word_out=4'hA with a 1-cycle word_valid. The FSM then enters CHECK.
//  3. In CHECK, send 1,1,0,1 -> sync_lock stays 1, frame_cnt=1, sync_err=0.
//     Next, 0,0,1,1 -> word_out=4'h3.
//  4. In CHECK, send 1,1,0,0 -> sync_err=1 for 1 cycle on the 4th bit, sync_lock=0, HUNT.
//     Next, 0,1,1,0 -> no word_valid.
//  5. Locked, send 1,x,0,x,0,x,1 with bit_valid=1,0,1,0,1,0,1 (x means bit_valid=0)
//     -> a single word_out=4'h9. Bits presented with bit_valid=0 are ignored.
//  6. Assert rst asynchronously (between edges) after 2 bits of a word -> all outputs are 0
//     before the next edge. After release, data without a sync word produces no word_valid.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
package rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    localparam int unsigned            DEF_SYNC_LEN     = 4;
    localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_PATTERN = 4'b1101;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial input and parallel result signals of the frame receiver.
interface serial_frame_receiver_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);

    logic             bit_in;
    logic             bit_valid;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             sync_lock;
    logic             sync_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output bit_in, bit_valid,
        input  word_out, word_valid, sync_lock, sync_err, frame_cnt
    );

    modport slave (
        input  bit_in, bit_valid,
        output word_out, word_valid, sync_lock, sync_err, frame_cnt
    );

endinterface

// File: rtl/serial_shift_in.sv
// N-bit MSB-first shift-in register; new bit enters at the LSB.
module serial_shift_in #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= N'({q, din});
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Sync-word hunting serial-to-parallel receiver with periodic sync re-check.
module serial_frame_receiver
    import rx_pkg::*;
#(
    parameter int unsigned         WIDTH        = 4,
    parameter int unsigned         SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int unsigned         FRAME_WORDS  = 2,
    parameter int unsigned         CNT_W        = 8
) (
    input logic                    clk,
    input logic                    rst,
    serial_frame_receiver_if.slave bus
);

    localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
    localparam int unsigned WORD_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);

    rx_state_e           state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [SYNC_W-1:0]   chk_cnt_q, chk_cnt_d;
    logic [SYNC_W-1:0]   fill_q, fill_d;
    logic                chk_err_q, chk_err_d;
    logic [SYNC_LEN-1:0] chk_pat_q, chk_pat_d;
    logic                chk_bad;

    logic [WIDTH-1:0]    word_out_q, word_out_d;
    logic                word_valid_q, word_valid_d;
    logic                sync_lock_q;
    logic                sync_err_q, sync_err_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic                win_en, win_clr, data_en, data_clr;
    logic [SYNC_LEN-1:0] win_q, win_next;
    logic [WIDTH-1:0]    data_q, data_next;

    // Both views include the bit being sampled this edge (zero-latency decisions).
    assign win_next  = SYNC_LEN'({win_q, bus.bit_in});
    assign data_next = WIDTH'({data_q, bus.bit_in});
    assign data_clr  = (state_q != ST_DATA);

    serial_shift_in #(.N(SYNC_LEN)) u_sync_win (
        .clk (clk),
        .rst (rst),
        .en  (win_en),
        .clr (win_clr),
        .din (bus.bit_in),
        .q   (win_q)
    );

    serial_shift_in #(.N(WIDTH)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (data_en),
        .clr (data_clr),
        .din (bus.bit_in),
        .q   (data_q)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        fill_d       = fill_q;
        chk_err_d    = chk_err_q;
        chk_pat_d    = chk_pat_q;
        chk_bad      = 1'b0;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        win_en       = 1'b0;
        win_clr      = 1'b0;
        data_en      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bus.bit_valid) begin
                    win_en = 1'b1;
                    if (fill_q != SYNC_W'(SYNC_LEN)) begin
                        fill_d = fill_q + SYNC_W'(1);
                    end
                    if ((fill_d == SYNC_W'(SYNC_LEN)) && (win_next == SYNC_PATTERN)) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end

            ST_DATA: begin
                if (bus.bit_valid) begin
                    data_en = 1'b1;
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        word_out_d   = data_next;
                        word_valid_d = 1'b1;
                        bit_cnt_d    = '0;
                        if (word_cnt_q == WORD_W'(FRAME_WORDS - 1)) begin
                            state_d    = ST_CHECK;
                            word_cnt_d = '0;
                            chk_cnt_d  = '0;
                            chk_err_d  = 1'b0;
                            chk_pat_d  = SYNC_PATTERN;
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                if (bus.bit_valid) begin
                    // Expected bit is always the MSB of a pattern copy shifted left per bit.
                    chk_bad   = chk_err_q | (bus.bit_in != chk_pat_q[SYNC_LEN-1]);
                    chk_pat_d = chk_pat_q << 1;
                    if (chk_cnt_q == SYNC_W'(SYNC_LEN - 1)) begin
                        chk_cnt_d  = '0;
                        chk_err_d  = 1'b0;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        if (chk_bad) begin
                            state_d    = ST_HUNT;
                            sync_err_d = 1'b1;
                            fill_d     = '0;
                            win_clr    = 1'b1;
                        end else begin
                            state_d     = ST_DATA;
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        chk_cnt_d = chk_cnt_q + SYNC_W'(1);
                        chk_err_d = chk_bad;
                    end
                end
            end

            default: begin
                state_d    = ST_HUNT;
                fill_d     = '0;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                chk_cnt_d  = '0;
                chk_err_d  = 1'b0;
                win_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            chk_cnt_q    <= '0;
            fill_q       <= '0;
            chk_err_q    <= 1'b0;
            chk_pat_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            sync_lock_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            fill_q       <= fill_d;
            chk_err_q    <= chk_err_d;
            chk_pat_q    <= chk_pat_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            sync_lock_q  <= (state_d == ST_DATA) || (state_d == ST_CHECK);
            sync_err_q   <= sync_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.sync_lock  = sync_lock_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed scenarios plus randomized framed streams vs. a word-level model.
module tb_serial_frame_receiver;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned SYNC_LEN    = 4;
    localparam int unsigned FRAME_WORDS = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned PAT         = 4'b1101;

    localparam int unsigned M_HUNT  = 0;
    localparam int unsigned M_DATA  = 1;
    localparam int unsigned M_CHECK = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_receiver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_frame_receiver #(
        .WIDTH        (WIDTH),
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (4'b1101),
        .FRAME_WORDS  (FRAME_WORDS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks;
    int unsigned failures;

    // Reference model: tracks received valid bits as integers per phase.
    int unsigned m_mode, m_hist, m_fill, m_acc, m_bits, m_words, m_chk, m_chk_n;
    int unsigned e_word, e_frame;
    logic        e_wv, e_lock, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_HUNT; m_hist = 0; m_fill = 0; m_acc = 0; m_bits = 0;
        m_words = 0; m_chk = 0; m_chk_n = 0;
        e_word = 0; e_frame = 0; e_wv = 1'b0; e_lock = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_step(input logic b, input logic v);
        e_wv  = 1'b0;
        e_err = 1'b0;
        if (v) begin
            if (m_mode == M_HUNT) begin
                m_hist = ((m_hist * 2) + b) % (1 << SYNC_LEN);
                if (m_fill < SYNC_LEN) m_fill++;
                if (m_fill == SYNC_LEN && m_hist == PAT) begin
                    m_mode = M_DATA; m_acc = 0; m_bits = 0; m_words = 0;
                end
            end else if (m_mode == M_DATA) begin
                m_acc = m_acc * 2 + b;
                m_bits++;
                if (m_bits == WIDTH) begin
                    e_word = m_acc; e_wv = 1'b1;
                    m_acc = 0; m_bits = 0; m_words++;
                    if (m_words == FRAME_WORDS) begin
                        m_mode = M_CHECK; m_words = 0; m_chk = 0; m_chk_n = 0;
                    end
                end
            end else begin
                m_chk = m_chk * 2 + b;
                m_chk_n++;
                if (m_chk_n == SYNC_LEN) begin
                    if (m_chk == PAT) begin
                        m_mode = M_DATA; m_acc = 0; m_bits = 0;
                        e_frame = (e_frame + 1) % (1 << CNT_W);
                    end else begin
                        m_mode = M_HUNT; e_err = 1'b1; m_fill = 0; m_hist = 0;
                    end
                end
            end
        end
        e_lock = (m_mode != M_HUNT);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "/word_out"},   bus.word_out,   e_word);
        check({tag, "/word_valid"}, bus.word_valid, e_wv);
        check({tag, "/sync_lock"},  bus.sync_lock,  e_lock);
        check({tag, "/sync_err"},   bus.sync_err,   e_err);
        check({tag, "/frame_cnt"},  bus.frame_cnt,  e_frame);
    endtask

    task automatic send_bit(input logic b, input logic v, input string tag);
        @(negedge clk);
        bus.bit_in    = b;
        bus.bit_valid = v;
        model_step(b, v);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_word(input logic [31:0] val, input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) send_bit(val[n-1-i], 1'b1, tag);
    endtask

    // Valid bits with random gaps of bit_valid=0 carrying random data.
    task automatic send_rand(input logic [31:0] val, input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) send_bit(1'($urandom), 1'b0, {tag, "_gap"});
            send_bit(val[n-1-i], 1'b1, tag);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        model_reset();
        #12;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Three pattern bits alone must not lock.
        send_word(32'b101, 3, "t1b");
        check("t1b_nolock", bus.sync_lock, 1'b0);
        apply_reset();

        send_word(32'b1101, 4, "t1");
        check("t1_lock", bus.sync_lock, 1'b1);
        check("t1_wv", bus.word_valid, 1'b0);

        send_word(32'b0110, 4, "t2a");
        check("t2_word6", bus.word_out, 4'h6);
        check("t2_wv6", bus.word_valid, 1'b1);
        send_bit(1'b0, 1'b0, "t2_idle");
        check("t2_wv_drop", bus.word_valid, 1'b0);
        send_word(32'b1010, 4, "t2b");
        check("t2_wordA", bus.word_out, 4'hA);

        send_word(32'b1101, 4, "t3_chk");
        check("t3_frame", bus.frame_cnt, 8'd1);
        check("t3_lock", bus.sync_lock, 1'b1);
        check("t3_err", bus.sync_err, 1'b0);
        send_word(32'b0011, 4, "t3_w");
        check("t3_word3", bus.word_out, 4'h3);
        send_word(32'b0000, 4, "t3_w2");

        send_word(32'b1100, 4, "t4_chk");
        check("t4_err", bus.sync_err, 1'b1);
        check("t4_unlock", bus.sync_lock, 1'b0);
        send_bit(1'b0, 1'b0, "t4_idle");
        check("t4_err_drop", bus.sync_err, 1'b0);
        send_word(32'b0110, 4, "t4_hunt");
        check("t4_nowv", bus.word_valid, 1'b0);
        send_word(32'b0000, 4, "t4_pad");

        send_word(32'b1101, 4, "t5_sync");
        send_bit(1'b1, 1'b1, "t5");
        send_bit(1'b0, 1'b0, "t5");
        send_bit(1'b0, 1'b1, "t5");
        send_bit(1'b1, 1'b0, "t5");
        send_bit(1'b0, 1'b1, "t5");
        send_bit(1'b1, 1'b0, "t5");
        send_bit(1'b1, 1'b1, "t5");
        check("t5_word9", bus.word_out, 4'h9);
        check("t5_wv", bus.word_valid, 1'b1);

        // Asynchronous reset in the middle of a word, between clock edges.
        send_bit(1'b1, 1'b1, "t6");
        send_bit(1'b0, 1'b1, "t6");
        #2;
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_async");
        check("t6_word_zero", bus.word_out, 4'h0);
        check("t6_lock_zero", bus.sync_lock, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_word(32'b0000_0110, 8, "t6_nosync");

        for (int unsigned f = 0; f < 60; f++) begin
            send_rand($urandom, $urandom_range(0, 3), "rnd_noise");
            send_rand(PAT, SYNC_LEN, "rnd_sync");
            for (int unsigned w = 0; w < FRAME_WORDS + 1; w++) begin
                send_rand($urandom, WIDTH, "rnd_data");
                send_rand(($urandom_range(0, 3) != 0) ? PAT : $urandom, SYNC_LEN, "rnd_trail");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
